// File: rtl/cfeb_pkg.sv
// Shared definitions for the SCA block manager: FSM state type, default sizes
// and a constant-foldable log2 helper.
package cfeb_pkg;

  localparam int NBLK_DEF  = 16;
  localparam int CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_WIN  = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/blk_fifo.sv
// Readout queue of SCA block indices; synchronous push/pop, head visible
// combinationally on dout_o whenever valid_o is high.
module blk_fifo
  import cfeb_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter int  WIDTH = 4,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST_B,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             wr, rd;

  assign wr      = push_i && (cnt_q != (AW+1)'(DEPTH));
  assign rd      = pop_i && (cnt_q != '0);
  assign valid_o = (cnt_q != '0);
  assign dout_o  = mem_q[rd_q];

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (rd) rd_q <= rd_q + AW'(1);
      case ({wr, rd})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sca_blk_mgr.sv
// SCA storage-block manager: LCT opens a delayed L1A window, a matching GTRG
// queues the current write block for readout and advances to the next free one.
module sca_blk_mgr
  import cfeb_pkg::*;
#(
  parameter int  NBLK  = NBLK_DEF,
  parameter int  CNT_W = CNT_W_DEF,
  localparam int BW    = clog2(NBLK)
) (
  input  logic             CLK,
  input  logic             RST_B,
  input  logic             LCT,
  input  logic             GTRG,
  input  logic [3:0]       L1A_DLY,
  input  logic [2:0]       L1A_WIN,
  input  logic             RD_DONE,
  output logic [BW-1:0]    WADR,
  output logic             PUSH,
  output logic             RD_VALID,
  output logic [BW-1:0]    RD_BLK,
  output logic [CNT_W-1:0] L1A_CNT,
  output logic [BW:0]      NFREE,
  output logic [7:0]       LOST_LCT,
  output logic             OVERFLOW
);

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic [2:0]       win_q;
  logic [BW-1:0]    wadr_q, push_blk_q;
  logic             push_q;
  logic [CNT_W-1:0] l1a_q;
  logic [BW:0]      nfree_q;
  logic [7:0]       lost_q;
  logic             ovf_q;
  logic [NBLK-1:0]  qd_q;

  logic             pop;
  logic             fifo_vld;
  logic [BW-1:0]    head;
  logic [NBLK-1:0]  avail_d;
  logic             nxt_ok_d;
  logic [BW-1:0]    nxt_d;

  assign pop = RD_DONE && fifo_vld;

  // Round-robin search: scan downward so the smallest offset above WADR wins.
  always_comb begin
    avail_d         = ~qd_q;
    avail_d[wadr_q] = 1'b0;
    nxt_ok_d        = 1'b0;
    nxt_d           = wadr_q;
    for (int i = NBLK - 1; i >= 1; i--) begin
      if (avail_d[wadr_q + BW'(i)]) begin
        nxt_ok_d = 1'b1;
        nxt_d    = wadr_q + BW'(i);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      win_q      <= '0;
      wadr_q     <= '0;
      push_blk_q <= '0;
      push_q     <= 1'b0;
      l1a_q      <= '0;
      nfree_q    <= (BW+1)'(NBLK);
      lost_q     <= '0;
      ovf_q      <= 1'b0;
      qd_q       <= '0;
    end else begin
      push_q <= 1'b0;
      case ({push_q, pop})
        2'b10:   nfree_q <= nfree_q - (BW+1)'(1);
        2'b01:   nfree_q <= nfree_q + (BW+1)'(1);
        default: ;
      endcase
      if (pop) qd_q[head] <= 1'b0;
      if (LCT && (state_q != ST_IDLE) && (lost_q != 8'hFF)) lost_q <= lost_q + 8'd1;

      case (state_q)
        ST_IDLE: begin
          if (LCT) begin
            win_q <= L1A_WIN;
            if (L1A_DLY == 4'd0) begin
              state_q <= ST_WIN;
              cnt_q   <= '0;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= L1A_DLY;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q <= ST_WIN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_WIN: begin
          if (GTRG) begin
            state_q <= ST_IDLE;
            l1a_q   <= l1a_q + CNT_W'(1);
            if (nxt_ok_d) begin
              push_q       <= 1'b1;
              push_blk_q   <= wadr_q;
              wadr_q       <= nxt_d;
              qd_q[wadr_q] <= 1'b1;
            end else begin
              ovf_q <= 1'b1;
            end
          end else if (cnt_q == {1'b0, win_q}) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Queue entry is written one cycle after the match, together with PUSH.
  blk_fifo #(
    .DEPTH(NBLK),
    .WIDTH(BW)
  ) u_fifo (
    .CLK    (CLK),
    .RST_B  (RST_B),
    .push_i (push_q),
    .din_i  (push_blk_q),
    .pop_i  (pop),
    .dout_o (head),
    .valid_o(fifo_vld)
  );

  assign WADR     = wadr_q;
  assign PUSH     = push_q;
  assign RD_VALID = fifo_vld;
  assign RD_BLK   = head;
  assign L1A_CNT  = l1a_q;
  assign NFREE    = nfree_q;
  assign LOST_LCT = lost_q;
  assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_sca_blk_mgr.sv
// Bench for sca_blk_mgr: event-level reference model (absolute window times,
// a block queue) compared every cycle, plus directed scenarios with literals.
module tb_sca_blk_mgr;

  localparam int NBLK  = 16;
  localparam int CNT_W = 6;
  localparam int BW    = 4;

  logic             CLK     = 1'b0;
  logic             RST_B   = 1'b1;
  logic             LCT     = 1'b0;
  logic             GTRG    = 1'b0;
  logic             RD_DONE = 1'b0;
  logic [3:0]       L1A_DLY = '0;
  logic [2:0]       L1A_WIN = '0;
  logic [BW-1:0]    WADR;
  logic             PUSH;
  logic             RD_VALID;
  logic [BW-1:0]    RD_BLK;
  logic [CNT_W-1:0] L1A_CNT;
  logic [BW:0]      NFREE;
  logic [7:0]       LOST_LCT;
  logic             OVERFLOW;

  sca_blk_mgr #(.NBLK(NBLK), .CNT_W(CNT_W)) dut (
    .CLK     (CLK),
    .RST_B   (RST_B),
    .LCT     (LCT),
    .GTRG    (GTRG),
    .L1A_DLY (L1A_DLY),
    .L1A_WIN (L1A_WIN),
    .RD_DONE (RD_DONE),
    .WADR    (WADR),
    .PUSH    (PUSH),
    .RD_VALID(RD_VALID),
    .RD_BLK  (RD_BLK),
    .L1A_CNT (L1A_CNT),
    .NFREE   (NFREE),
    .LOST_LCT(LOST_LCT),
    .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  int nchecks = 0;
  int nerrs   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    nchecks++;
    if (act != exp) begin
      nerrs++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: events described by absolute window start/end cycles.
  int     mq[$];
  int     m_wadr, m_pblk, m_l1a, m_lost;
  bit     m_push, m_ovf, m_busy;
  longint m_cyc, m_ws, m_we;

  function automatic bit m_owned(input int b);
    if (b == m_wadr) return 1'b1;
    if (m_push && (b == m_pblk)) return 1'b1;
    foreach (mq[i]) if (mq[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_reset();
    mq.delete();
    m_wadr = 0; m_pblk = 0; m_l1a = 0; m_lost = 0;
    m_push = 1'b0; m_ovf = 1'b0; m_busy = 1'b0;
  endtask

  task automatic m_step();
    bit old_busy, in_win, npush, found;
    int nblk, b;
    old_busy = m_busy;
    in_win   = m_busy && (m_cyc >= m_ws) && (m_cyc <= m_we);
    npush    = 1'b0;
    nblk     = 0;
    if (in_win && GTRG) begin
      m_l1a++;
      m_busy = 1'b0;
      found  = 1'b0;
      for (int i = 1; i < NBLK; i++) begin
        b = (m_wadr + i) % NBLK;
        if (!found && !m_owned(b)) begin
          found = 1'b1;
          npush = 1'b1;
          nblk  = m_wadr;
          m_wadr = b;
        end
      end
      if (!found) m_ovf = 1'b1;
    end else if (in_win && (m_cyc == m_we)) begin
      m_busy = 1'b0;
    end
    if (LCT) begin
      if (old_busy) begin
        if (m_lost < 255) m_lost++;
      end else begin
        m_busy = 1'b1;
        m_ws   = m_cyc + 1 + longint'(L1A_DLY);
        m_we   = m_ws + longint'(L1A_WIN);
      end
    end
    if (RD_DONE && (mq.size() > 0)) void'(mq.pop_front());
    if (m_push) mq.push_back(m_pblk);
    m_push = npush;
    m_pblk = nblk;
    m_cyc++;
  endtask

  initial begin
    m_cyc = 0; m_ws = 0; m_we = 0;
    m_reset();
  end

  always @(posedge CLK or negedge RST_B) begin
    if (!RST_B) m_reset();
    else        m_step();
  end

  always @(negedge CLK) begin
    chk("WADR", longint'(WADR), m_wadr);
    chk("PUSH", longint'(PUSH), m_push);
    chk("RD_VALID", longint'(RD_VALID), (mq.size() != 0));
    if (mq.size() != 0) chk("RD_BLK", longint'(RD_BLK), mq[0]);
    chk("L1A_CNT", longint'(L1A_CNT), m_l1a % (1 << CNT_W));
    chk("NFREE", longint'(NFREE), NBLK - mq.size());
    chk("LOST_LCT", longint'(LOST_LCT), m_lost);
    chk("OVERFLOW", longint'(OVERFLOW), m_ovf);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_B = 1'b0; LCT = 1'b0; GTRG = 1'b0; RD_DONE = 1'b0;
    repeat (2) tick();
    RST_B = 1'b1;
    tick();
  endtask

  // LCT now; GTRG in window cycle 'off'; returns in the cycle after GTRG.
  task automatic match_evt(input int d, input int w, input int off);
    LCT = 1'b1; L1A_DLY = 4'(d); L1A_WIN = 3'(w);
    tick();
    LCT = 1'b0;
    repeat (d + off) tick();
    GTRG = 1'b1;
    tick();
    GTRG = 1'b0;
  endtask

  int rdp;

  initial begin
    #1 do_reset();
    chk("rst_WADR", longint'(WADR), 0);
    chk("rst_NFREE", longint'(NFREE), 16);
    chk("rst_RD_VALID", longint'(RD_VALID), 0);

    // Basic match with DLY=3, WIN=1
    match_evt(3, 1, 0);
    chk("s1_PUSH", longint'(PUSH), 1);
    chk("s1_WADR", longint'(WADR), 1);
    chk("s1_RD_BLK", longint'(RD_BLK), 0);
    chk("s1_L1A_CNT", longint'(L1A_CNT), 1);
    chk("s1_NFREE", longint'(NFREE), 16);

    // Late GTRG and a lost LCT
    do_reset();
    LCT = 1'b1; L1A_DLY = 4'd3; L1A_WIN = 3'd1;
    tick(); LCT = 1'b0;
    tick(); LCT = 1'b1;
    tick(); LCT = 1'b0;
    repeat (3) tick();
    GTRG = 1'b1;
    tick(); GTRG = 1'b0;
    chk("s2_PUSH", longint'(PUSH), 0);
    chk("s2_WADR", longint'(WADR), 0);
    chk("s2_LOST", longint'(LOST_LCT), 1);

    // Fill all blocks, then overflow
    do_reset();
    repeat (15) match_evt(0, 0, 0);
    chk("s3_WADR", longint'(WADR), 15);
    tick();
    chk("s3_NFREE", longint'(NFREE), 1);
    match_evt(0, 0, 0);
    chk("s3_OVF", longint'(OVERFLOW), 1);
    chk("s3_PUSH", longint'(PUSH), 0);
    chk("s3_L1A_CNT", longint'(L1A_CNT), 16);
    chk("s3_WADR2", longint'(WADR), 15);

    // Pop on the same cycle as a push
    do_reset();
    repeat (3) match_evt(0, 0, 0);
    tick();
    chk("s4_NFREE0", longint'(NFREE), 13);
    match_evt(0, 0, 0);
    RD_DONE = 1'b1;
    tick();
    RD_DONE = 1'b0;
    chk("s4_RD_BLK", longint'(RD_BLK), 1);
    chk("s4_NFREE", longint'(NFREE), 13);

    // Reset in the middle of a window with blocks queued
    do_reset();
    repeat (3) match_evt(0, 0, 0);
    tick();
    LCT = 1'b1; L1A_DLY = 4'd0; L1A_WIN = 3'd7;
    tick(); LCT = 1'b0;
    #2 RST_B = 1'b0;
    #1;
    chk("s5_WADR", longint'(WADR), 0);
    chk("s5_PUSH", longint'(PUSH), 0);
    chk("s5_RD_VALID", longint'(RD_VALID), 0);
    chk("s5_RD_BLK", longint'(RD_BLK), 0);
    chk("s5_L1A_CNT", longint'(L1A_CNT), 0);
    chk("s5_NFREE", longint'(NFREE), 16);
    chk("s5_LOST", longint'(LOST_LCT), 0);
    chk("s5_OVF", longint'(OVERFLOW), 0);
    tick();
    RST_B = 1'b1;
    GTRG  = 1'b1;
    repeat (3) tick();
    GTRG = 1'b0;
    chk("s5_PUSH_after", longint'(PUSH), 0);
    chk("s5_L1A_after", longint'(L1A_CNT), 0);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rdp = (c < 2000) ? 24 : 3;
      LCT = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) L1A_DLY = 4'($urandom_range(0, 15));
      else                           L1A_DLY = 4'($urandom_range(0, 3));
      L1A_WIN = 3'($urandom_range(0, 7));
      GTRG    = ($urandom_range(0, 3) == 0);
      RD_DONE = ($urandom_range(0, rdp - 1) == 0);
      if (c == 2500) begin
        #1 RST_B = 1'b0;
        #1 RST_B = 1'b1;
      end
      tick();
    end
    LCT = 1'b0; GTRG = 1'b0; RD_DONE = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule

// File: doc/sca_blk_mgr.md
SCA_BLK_MGR -- requirements
Module: sca_blk_mgr

Interface
REQ-001 The block SHALL have parameter NBLK, default 16, number of SCA storage blocks (power of 2, 4..64); BW = clog2(NBLK).
REQ-002 The block SHALL have parameter CNT_W, default 6, width of the L1A event counter.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all logic on rising edge.
REQ-004 The block SHALL have port RST_B, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port LCT, input, 1 bit: synchronous local-trigger strobe.
REQ-006 The block SHALL have port GTRG, input, 1 bit: synchronous global L1A strobe.
REQ-007 The block SHALL have port L1A_DLY, input, 4 bits: cycles from LCT to window open; sampled on the accepted LCT.
REQ-008 The block SHALL have port L1A_WIN, input, 3 bits: window length minus 1; sampled on the accepted LCT.
REQ-009 The block SHALL have port RD_DONE, input, 1 bit: readout of the head block is finished.
REQ-010 The block SHALL have port WADR, output, BW bits: block currently being written.
REQ-011 The block SHALL have port PUSH, output, 1 bit: one-cycle pulse when an event is queued.
REQ-012 The block SHALL have port RD_VALID, output, 1 bit: readout queue not empty.
REQ-013 The block SHALL have port RD_BLK, output, BW bits: block at the head of the queue.
REQ-014 The block SHALL have port L1A_CNT, output, CNT_W bits: matched-L1A count, wraps.
REQ-015 The block SHALL have port NFREE, output, BW+1 bits: number of blocks not queued (the write block is included).
REQ-016 The block SHALL have port LOST_LCT, output, 8 bits: saturating count of LCTs ignored while busy.
REQ-017 The block SHALL have port OVERFLOW, output, 1 bit: sticky flag, event dropped for lack of a free block.

Function
REQ-018 The FSM SHALL have states IDLE, WAIT, WIN.
REQ-019 IDLE: LCT=1 SHALL latch L1A_DLY and L1A_WIN, then go to WAIT (DLY>0) or WIN (DLY=0) on the next cycle.
REQ-020 WAIT SHALL last exactly L1A_DLY cycles, then go to WIN.
REQ-021 WIN SHALL last at most L1A_WIN+1 cycles; GTRG=1 in any WIN cycle is a match.
REQ-022 Window expiry without a match SHALL return to IDLE with WADR unchanged (the block is reused).
REQ-023 On a match, in the cycle after GTRG: if another free block exists, PUSH=1, the old WADR is written to the queue, WADR takes the next free block, and the FSM goes to IDLE.
REQ-024 Next free block SHALL be the lowest free index above WADR, wrapping modulo NBLK (round robin).
REQ-025 On a match with no other free block: OVERFLOW SHALL be set, PUSH=0, the queue SHALL be unchanged, WADR SHALL be unchanged, and the FSM goes to IDLE.
REQ-026 L1A_CNT SHALL increment by 1 on every match, including dropped ones, and wrap at 2^CNT_W.
REQ-027 LCT in WAIT or WIN SHALL be ignored and LOST_LCT incremented, saturating at 255.
REQ-028 GTRG outside WIN SHALL be ignored; only the first GTRG in a window counts.
REQ-029 RD_DONE with RD_VALID=1 SHALL pop the head and mark that block free one cycle later; RD_DONE with RD_VALID=0 SHALL be ignored.
REQ-030 A block freed in cycle t SHALL NOT be allocatable before cycle t+1; a simultaneous pop and push SHALL both complete.
REQ-031 The readout queue SHALL be NBLK deep and can never overflow; RD_BLK SHALL be valid whenever RD_VALID=1.
REQ-032 NFREE SHALL equal NBLK minus queue occupancy and be registered; PUSH/RD_DONE in the same cycle SHALL leave it unchanged.

Reset
REQ-033 RST_B=0 SHALL asynchronously force: FSM=IDLE, WADR=0, all blocks free, queue empty, PUSH=0, RD_VALID=0, RD_BLK=0, L1A_CNT=0, NFREE=NBLK, LOST_LCT=0, OVERFLOW=0.
REQ-034 Reset mid-window or mid-readout SHALL abandon all pending events with no PUSH; OVERFLOW SHALL be cleared only by reset.

Structure
REQ-035 A shared package cfeb_pkg SHALL hold the FSM state type, a clog2 function, and the default NBLK and CNT_W constants.
REQ-036 The readout queue SHALL be a sub-module blk_fifo (parameters depth and width) with synchronous push/pop and the same CLK/RST_B.

Verification
REQ-037 Scenario: DLY=3, WIN=1, LCT at t0, GTRG at t0+4 -> PUSH at t0+5, RD_BLK=0, WADR=1, L1A_CNT=1, NFREE=16.
REQ-038 Scenario: LCT, then GTRG at t0+6 with DLY=3, WIN=1 -> no PUSH, WADR=0; a second LCT at t0+2 -> LOST_LCT=1.
REQ-039 Scenario: 15 matches with no RD_DONE -> WADR=15, NFREE=1; a 16th match -> OVERFLOW=1, no PUSH, L1A_CNT=16.
REQ-040 Scenario: queue holds blocks 0..2; RD_DONE on the same cycle as a match PUSH -> RD_BLK=1, NFREE unchanged, block 0 allocatable next cycle.
REQ-041 Scenario: free blocks {2,9}, WADR=2 -> match allocates 9; after release of 0 and use of 9, the next allocation wraps to 0.
REQ-042 Scenario: RST_B low during WIN with 3 queued -> all outputs at REQ-033 values immediately; GTRG afterwards -> no PUSH.
